// File: rtl/des_round_ctrl.sv
// rtl/des_round_ctrl.sv - DES Feistel round sequencer over shared f-function and registered XOR stage
// One f request then one XOR request per round; result is the swap-undone R16||L16.
module des_round_ctrl #(
  parameter int ROUNDS      = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                                   clk_in,
  input  logic                                   rst_n_in,
  input  logic                                   start_in,
  input  logic                                   decrypt_in,
  input  logic [63:0]                            block_in,
  output logic                                   ready_out,
  output logic                                   f_req_out,
  output logic [31:0]                            f_data_out,
  output logic [((ROUNDS > 1) ? $clog2(ROUNDS) : 1)-1:0] key_idx_out,
  input  logic                                   f_valid_in,
  input  logic [31:0]                            f_data_in,
  output logic                                   xor_valid_out,
  output logic [31:0]                            xor_left_out,
  output logic [31:0]                            xor_right_out,
  input  logic                                   xor_valid_in,
  input  logic [31:0]                            xor_data_in,
  output logic [63:0]                            block_out,
  output logic                                   block_out_valid,
  output logic                                   err_out
);

  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 2);
  localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);

  typedef enum logic [2:0] {IDLE, F_REQ, F_WAIT, X_REQ, X_WAIT, DONE} state_t;

  state_t        state;
  logic [RW-1:0] round;
  logic          dec;
  logic [31:0]   l_reg;
  logic [31:0]   r_reg;
  logic [31:0]   f_reg;
  logic [TW-1:0] tcnt;
  logic          expire;

  // Expiry is the last wait cycle; a valid seen in that same cycle takes priority.
  assign expire = (TIMEOUT_CYC != 0) && (int'(tcnt) == TIMEOUT_CYC - 1);

  assign f_data_out    = r_reg;
  assign xor_left_out  = l_reg;
  assign xor_right_out = f_reg;
  assign block_out     = {r_reg, l_reg};

  function automatic logic [RW-1:0] key_of(input logic d, input logic [RW-1:0] r);
    return d ? (LAST - r) : r;
  endfunction

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= IDLE;
      round           <= '0;
      dec             <= 1'b0;
      l_reg           <= '0;
      r_reg           <= '0;
      f_reg           <= '0;
      tcnt            <= '0;
      ready_out       <= 1'b1;
      f_req_out       <= 1'b0;
      key_idx_out     <= '0;
      xor_valid_out   <= 1'b0;
      block_out_valid <= 1'b0;
      err_out         <= 1'b0;
    end else begin
      f_req_out       <= 1'b0;
      xor_valid_out   <= 1'b0;
      block_out_valid <= 1'b0;
      err_out         <= 1'b0;
      case (state)
        IDLE: begin
          // After an abort ready_out stays low for the err_out cycle, so start is not sampled then.
          if (ready_out && start_in) begin
            l_reg       <= block_in[63:32];
            r_reg       <= block_in[31:0];
            dec         <= decrypt_in;
            round       <= '0;
            key_idx_out <= key_of(decrypt_in, '0);
            ready_out   <= 1'b0;
            f_req_out   <= 1'b1;
            state       <= F_REQ;
          end else begin
            ready_out <= 1'b1;
          end
        end
        F_REQ: begin
          tcnt  <= '0;
          state <= F_WAIT;
        end
        F_WAIT: begin
          if (f_valid_in) begin
            f_reg         <= f_data_in;
            xor_valid_out <= 1'b1;
            state         <= X_REQ;
          end else if (expire) begin
            err_out <= 1'b1;
            state   <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        X_REQ: begin
          tcnt  <= '0;
          state <= X_WAIT;
        end
        X_WAIT: begin
          if (xor_valid_in) begin
            l_reg <= r_reg;
            r_reg <= xor_data_in;
            if (round == LAST) begin
              block_out_valid <= 1'b1;
              state           <= DONE;
            end else begin
              round       <= round + 1'b1;
              key_idx_out <= key_of(dec, round + 1'b1);
              f_req_out   <= 1'b1;
              state       <= F_REQ;
            end
          end else if (expire) begin
            err_out <= 1'b1;
            state   <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DONE: begin
          ready_out <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          ready_out <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
